// File: rtl/note_seq_pkg.sv
// Shared definitions for the chart sequencer: note codes used by the
// sequencer, hit-judge and note-scroll logic, plus default geometry.
package note_seq_pkg;

    // Default chart geometry
    localparam int NOTE_W_DFLT    = 3;
    localparam int CHART_LEN_DFLT = 64;
    localparam int AW_DFLT        = 6;
    localparam int STEP_W_DFLT    = 8;

    // Note codes; code 0 is a rest and never produces a strobe
    localparam logic [2:0] NOTE_REST   = 3'd0;
    localparam logic [2:0] NOTE_DO     = 3'd1;
    localparam logic [2:0] NOTE_KA     = 3'd2;
    localparam logic [2:0] NOTE_BIG_DO = 3'd3;
    localparam logic [2:0] NOTE_BIG_KA = 3'd4;

endpackage

// File: rtl/note_seq_frame_div.sv
// Tempo counter: counts vsync frames inside one chart step. The step
// length is captured on the first frame of each step so a tempo change
// takes effect cleanly at the next step boundary. A programmed length of
// zero is treated as one frame per step.
module note_seq_frame_div
    import note_seq_pkg::*;
#(
    parameter int STEP_W = STEP_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              en,
    input  logic              clr,
    input  logic [STEP_W-1:0] step_frames,
    output logic              step_start,
    output logic              step_end
);

    logic [STEP_W-1:0] frame_cnt_r;
    logic [STEP_W-1:0] step_reg_r;
    logic [STEP_W-1:0] step_eff_s;
    logic [STEP_W-1:0] step_len_s;
    logic              first_frame_s;
    logic              count_s;

    assign first_frame_s = (frame_cnt_r == {STEP_W{1'b0}});
    assign count_s       = en & vsync;

    // Clamp a zero step length to one frame
    always_comb begin
        step_eff_s = step_frames;
        if (step_frames == {STEP_W{1'b0}}) begin
            step_eff_s = {{(STEP_W-1){1'b0}}, 1'b1};
        end else begin
            step_eff_s = step_frames;
        end
    end

    // Length in force for this frame: on the first frame the freshly
    // clamped value is used so a one-frame step starts and ends together
    always_comb begin
        step_len_s = step_reg_r;
        if (first_frame_s) begin
            step_len_s = step_eff_s;
        end else begin
            step_len_s = step_reg_r;
        end
    end

    assign step_start = count_s & first_frame_s;
    assign step_end   = count_s & (frame_cnt_r == (step_len_s - {{(STEP_W-1){1'b0}}, 1'b1}));

    // Frame counter and captured step length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= {STEP_W{1'b0}};
            step_reg_r  <= {STEP_W{1'b0}};
        end else if (clr) begin
            frame_cnt_r <= {STEP_W{1'b0}};
            step_reg_r  <= step_reg_r;
        end else if (count_s) begin
            if (first_frame_s) begin
                step_reg_r <= step_eff_s;
            end else begin
                step_reg_r <= step_reg_r;
            end
            if (step_end) begin
                frame_cnt_r <= {STEP_W{1'b0}};
            end else begin
                frame_cnt_r <= frame_cnt_r + {{(STEP_W-1){1'b0}}, 1'b1};
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
            step_reg_r  <= step_reg_r;
        end
    end

endmodule

// File: rtl/note_seq.sv
// Chart sequencer: walks a chart stored in an external ROM at a
// programmable tempo (in vsync frames per step) and emits one-cycle note
// strobes for the hit-judge and note-scroll logic. Supports start/stop,
// pause, loop or one-shot playback and a done flag.
module note_seq
    import note_seq_pkg::*;
#(
    parameter int NOTE_W    = NOTE_W_DFLT,
    parameter int CHART_LEN = CHART_LEN_DFLT,
    parameter int AW        = AW_DFLT,
    parameter int STEP_W    = STEP_W_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 loop_en,
    input  logic [STEP_W-1:0]    step_frames,
    output logic [AW-1:0]        rom_addr,
    input  logic [NOTE_W-1:0]    rom_data,
    output logic                 note_valid,
    output logic [NOTE_W-1:0]    note_code,
    output logic [AW-1:0]        note_idx,
    output logic [2**NOTE_W-1:0] request,
    output logic                 busy,
    output logic                 done
);

    localparam int              REQ_W    = 2**NOTE_W;
    localparam logic [AW-1:0]   LAST_IDX = AW'(CHART_LEN - 1);
    localparam logic [AW-1:0]   IDX_ONE  = AW'(1);

    // PRIME and FETCH both spend one cycle capturing the ROM word; PRIME
    // is the first fetch after start, FETCH follows every step advance
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_FETCH = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    seq_state_e        state_r;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     rom_addr_r;
    logic [NOTE_W-1:0] note_buf_r;
    logic              note_valid_r;
    logic [NOTE_W-1:0] note_code_r;
    logic [AW-1:0]     note_idx_r;
    logic [REQ_W-1:0]  request_r;
    logic              busy_r;
    logic              done_r;

    logic              div_en_s;
    logic              div_clr_s;
    logic              step_start_s;
    logic              step_end_s;
    logic              last_idx_s;
    logic              note_hit_s;

    assign last_idx_s = (idx_r == LAST_IDX);
    assign note_hit_s = (note_buf_r != NOTE_W'(NOTE_REST));

    // Tempo counter runs only while actively playing; start/stop zero it
    always_comb begin
        div_en_s  = 1'b0;
        div_clr_s = 1'b0;
        if (stop || start) begin
            div_clr_s = 1'b1;
        end else if ((state_r == ST_RUN) && !pause) begin
            div_en_s = 1'b1;
        end else begin
            div_en_s = 1'b0;
        end
    end

    note_seq_frame_div #(
        .STEP_W (STEP_W)
    ) u_frame_div (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .en          (div_en_s),
        .clr         (div_clr_s),
        .step_frames (step_frames),
        .step_start  (step_start_s),
        .step_end    (step_end_s)
    );

    // Sequencer FSM with chart index, ROM addressing and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {AW{1'b0}};
            rom_addr_r   <= {AW{1'b0}};
            note_buf_r   <= {NOTE_W{1'b0}};
            note_valid_r <= 1'b0;
            note_code_r  <= {NOTE_W{1'b0}};
            note_idx_r   <= {AW{1'b0}};
            request_r    <= {REQ_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            // Strobes default low so every pulse lasts exactly one cycle
            note_valid_r <= 1'b0;
            note_code_r  <= {NOTE_W{1'b0}};
            note_idx_r   <= {AW{1'b0}};
            request_r    <= {REQ_W{1'b0}};
            if (stop) begin
                state_r    <= ST_IDLE;
                idx_r      <= {AW{1'b0}};
                rom_addr_r <= {AW{1'b0}};
                busy_r     <= 1'b0;
                done_r     <= 1'b0;
            end else if (start) begin
                state_r    <= ST_PRIME;
                idx_r      <= {AW{1'b0}};
                rom_addr_r <= {AW{1'b0}};
                busy_r     <= 1'b1;
                done_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                    ST_PRIME, ST_FETCH: begin
                        // A pending pause still lets the fetch complete
                        note_buf_r <= rom_data;
                        busy_r     <= 1'b1;
                        if (pause) begin
                            state_r <= ST_PAUSE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state_r <= ST_PAUSE;
                        end else begin
                            if (step_start_s && note_hit_s) begin
                                note_valid_r          <= 1'b1;
                                note_code_r           <= note_buf_r;
                                note_idx_r            <= idx_r;
                                request_r[note_buf_r] <= 1'b1;
                            end
                            if (step_end_s) begin
                                if (!last_idx_s) begin
                                    idx_r      <= idx_r + IDX_ONE;
                                    rom_addr_r <= idx_r + IDX_ONE;
                                    state_r    <= ST_FETCH;
                                end else if (loop_en) begin
                                    idx_r      <= {AW{1'b0}};
                                    rom_addr_r <= {AW{1'b0}};
                                    state_r    <= ST_FETCH;
                                end else begin
                                    state_r <= ST_DONE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        // Counters are frozen; resume at the held frame count
                        busy_r <= 1'b1;
                        if (pause) begin
                            state_r <= ST_PAUSE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = rom_addr_r;
    assign note_valid = note_valid_r;
    assign note_code  = note_code_r;
    assign note_idx   = note_idx_r;
    assign request    = request_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
